// File: rtl/wb_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_reader
//  Purpose  : Wishbone registered-feedback read master.  Streams a linear
//             block of 32-bit words from a Wishbone slave into a downstream
//             FIFO.  The block is split into incrementing bursts of at most
//             BURST words.  A burst starts only when the FIFO guarantees room
//             for the whole burst.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADR_W      Wishbone byte-address width
//    LEN_W      width of the word-count field
//    BURST      maximum words per burst (power of two, 2..256)
//  Ports
//    clk, rst_n                   clock, asynchronous active-low reset
//    cmd_valid/cmd_ready          transfer request handshake
//    cmd_adr                      start byte address (bits [1:0] ignored)
//    cmd_len                      number of words (0 = no bus activity)
//    done                         one-cycle completion pulse
//    wb_cyc/wb_stb/wb_we/wb_sel   Wishbone master control
//    wb_adr/wb_cti/wb_bte         Wishbone address and burst signalling
//    wb_dat_ms/wb_dat_sm          Wishbone write / read data
//    wb_ack                       slave acknowledge
//    fifo_afull                   low = at least BURST free FIFO entries
//    fifo_wdata/fifo_we           FIFO push interface
// ============================================================================
module wb_burst_reader #(
    parameter int ADR_W = 32,
    parameter int LEN_W = 16,
    parameter int BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // command interface
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             done,
    // Wishbone master
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [3:0]       wb_sel,
    output logic [ADR_W-1:0] wb_adr,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    output logic [31:0]      wb_dat_ms,
    input  logic [31:0]      wb_dat_sm,
    input  logic             wb_ack,
    // FIFO push side
    input  logic             fifo_afull,
    output logic [31:0]      fifo_wdata,
    output logic             fifo_we
);

    // beat counter must be able to hold BURST itself, hence the extra bit
    localparam int c_BEAT_W = $clog2(BURST) + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] c_CTI_INCR    = 3'b010;
    localparam logic [2:0] c_CTI_END     = 3'b111;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [ADR_W-1:0]    r_adr;
    logic [LEN_W-1:0]    r_remaining;
    logic [c_BEAT_W-1:0] r_beats;       // beats left in the current burst, including the one on the bus
    logic                r_single;      // current burst is one beat long: classic cycle
    logic                r_done;
    logic                r_fifo_we;
    logic [31:0]         r_fifo_wdata;

    logic [c_BEAT_W-1:0] w_bl;
    logic                w_ack_beat;
    logic                w_last_beat;
    logic                w_accept;
    logic                w_zero_cmd;

    // ------------------------------------------------------------------
    // Helper decodes
    // ------------------------------------------------------------------
    always_comb begin
        if (r_remaining >= LEN_W'(BURST)) begin
            w_bl = c_BEAT_W'(BURST);
        end else begin
            w_bl = r_remaining[c_BEAT_W-1:0];
        end
    end

    assign w_ack_beat  = (r_state == c_ST_BURST) && wb_ack;
    assign w_last_beat = (r_beats == c_BEAT_W'(1));
    assign w_accept    = (r_state == c_ST_IDLE) && cmd_valid;
    assign w_zero_cmd  = (cmd_len == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid && !w_zero_cmd) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                // afull is only looked at here; once a burst starts the
                // FIFO has already promised room for all of it
                if (!fifo_afull) begin
                    w_state_nxt = c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                if (wb_ack && w_last_beat) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (r_remaining == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        wb_cyc    = 1'b0;
        wb_cti    = c_CTI_CLASSIC;
        case (r_state)
            c_ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            c_ST_BURST: begin
                wb_cyc = 1'b1;
                if (r_single) begin
                    wb_cti = c_CTI_CLASSIC;
                end else if (w_last_beat) begin
                    wb_cti = c_CTI_END;
                end else begin
                    wb_cti = c_CTI_INCR;
                end
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr       <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_single    <= 1'b0;
        end else begin
            if (w_accept) begin
                // masking keeps the start address word aligned
                r_adr       <= cmd_adr & ~ADR_W'(3);
                r_remaining <= cmd_len;
            end
            if ((r_state == c_ST_WAIT) && !fifo_afull) begin
                r_beats  <= w_bl;
                r_single <= (w_bl == c_BEAT_W'(1));
            end
            if (w_ack_beat) begin
                // address wraps naturally modulo 2^ADR_W
                r_adr       <= r_adr + ADR_W'(4);
                r_remaining <= r_remaining - LEN_W'(1);
                r_beats     <= r_beats - c_BEAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO push and completion pulse, both registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_we    <= 1'b0;
            r_fifo_wdata <= '0;
            r_done       <= 1'b0;
        end else begin
            r_fifo_we <= w_ack_beat;
            if (w_ack_beat) begin
                r_fifo_wdata <= wb_dat_sm;
            end
            // GAP with nothing left means the final push is going out
            // this cycle; done follows it by one cycle
            r_done <= (w_accept && w_zero_cmd) ||
                      ((r_state == c_ST_GAP) && (r_remaining == '0));
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign done       = r_done;
    assign wb_stb     = wb_cyc;
    assign wb_we      = 1'b0;
    assign wb_sel     = 4'hF;
    assign wb_adr     = r_adr;
    assign wb_bte     = 2'b00;
    assign wb_dat_ms  = 32'h0;
    assign fifo_we    = r_fifo_we;
    assign fifo_wdata = r_fifo_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_burst_reader
//  Purpose  : Self-checking bench for wb_burst_reader.  A behavioural slave
//             returns word-address-as-data; a reference model expands each
//             command into the expected beat list (address, CTI, burst end)
//             and the expected FIFO word stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_burst_reader;

    localparam int ADR_W = 32;
    localparam int LEN_W = 16;
    localparam int BURST = 16;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ADR_W-1:0] cmd_adr;
    logic [LEN_W-1:0] cmd_len;
    logic             done;
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [3:0]       wb_sel;
    logic [ADR_W-1:0] wb_adr;
    logic [2:0]       wb_cti;
    logic [1:0]       wb_bte;
    logic [31:0]      wb_dat_ms;
    logic [31:0]      wb_dat_sm;
    logic             wb_ack;
    logic             fifo_afull;
    logic [31:0]      fifo_wdata;
    logic             fifo_we;

    wb_burst_reader #(.ADR_W(ADR_W), .LEN_W(LEN_W), .BURST(BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .done       (done),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_sel     (wb_sel),
        .wb_adr     (wb_adr),
        .wb_cti     (wb_cti),
        .wb_bte     (wb_bte),
        .wb_dat_ms  (wb_dat_ms),
        .wb_dat_sm  (wb_dat_sm),
        .wb_ack     (wb_ack),
        .fifo_afull (fifo_afull),
        .fifo_wdata (fifo_wdata),
        .fifo_we    (fifo_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        bit          last;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_data[$];

    int total = 0;
    int bad   = 0;

    // control of the behavioural slave / FIFO model
    bit wait_mode  = 0;
    bit afull_rand = 0;
    int hold_at_beat = 0;
    int hold_left    = 0;

    // monitor state
    int beats_seen = 0;
    int done_cnt   = 0;
    int cur_len    = 0;
    bit prev_cyc   = 0;
    bit prev_afull = 0;
    bit prev_we    = 0;
    bit gap_next   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: split a command into bursts and list every beat
    task automatic build_model(input logic [31:0] adr, input int len);
        logic [31:0] a;
        int rem;
        int bl;
        beat_t b;
        a   = adr & ~32'd3;
        rem = len;
        while (rem > 0) begin
            bl = (rem > BURST) ? BURST : rem;
            for (int k = 0; k < bl; k++) begin
                b.adr  = a;
                b.cti  = (bl == 1) ? 3'b000 : ((k == bl - 1) ? 3'b111 : 3'b010);
                b.last = (k == bl - 1);
                exp_beats.push_back(b);
                exp_data.push_back((a >> 2) & 32'h3FFF_FFFF);
                a = a + 32'd4;
            end
            rem = rem - bl;
        end
    endtask

    // Slave, afull driver and output monitor, all on the falling edge
    always @(negedge clk) begin
        beat_t b;
        logic [31:0] d;
        if (!rst_n) begin
            wb_ack     = 1'b0;
            wb_dat_sm  = 32'h0;
            fifo_afull = 1'b0;
            prev_cyc   = 0;
            prev_afull = 0;
            prev_we    = 0;
            gap_next   = 0;
            hold_left  = 0;
        end else begin
            if (wb_cyc !== wb_stb) check("cyc_eq_stb", {63'd0, wb_stb}, {63'd0, wb_cyc});
            if (!prev_cyc && prev_afull) check("afull_block", {63'd0, wb_cyc}, 64'd0);
            if (hold_left > 0) check("afull_hold_cyc", {63'd0, wb_cyc}, 64'd0);
            if (gap_next) begin
                check("gap_cyc", {63'd0, wb_cyc}, 64'd0);
                gap_next = 0;
            end
            if (fifo_we) begin
                if (exp_data.size() == 0) begin
                    check("push_extra", 64'd1, 64'd0);
                end else begin
                    d = exp_data.pop_front();
                    check("push_data", {32'd0, fifo_wdata}, {32'd0, d});
                end
            end
            if (done) begin
                done_cnt++;
                check("done_pending", 64'(exp_data.size()), 64'd0);
                if (cur_len != 0) check("done_timing", {63'd0, prev_we}, 64'd1);
            end
            // slave response for this cycle
            wb_ack    = wb_cyc && (!wait_mode || ($urandom_range(0, 2) != 0));
            wb_dat_sm = wb_ack ? {2'b00, wb_adr[31:2]} : $urandom;
            if (wb_ack) begin
                beats_seen++;
                check("ready_busy", {63'd0, cmd_ready}, 64'd0);
                if (exp_beats.size() == 0) begin
                    check("beat_extra", 64'd1, 64'd0);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_adr", {32'd0, wb_adr}, {32'd0, b.adr});
                    check("beat_cti", {61'd0, wb_cti}, {61'd0, b.cti});
                    gap_next = b.last;
                end
            end
            // FIFO almost-full model
            if (hold_at_beat != 0 && wb_ack && beats_seen == hold_at_beat) begin
                hold_left    = 20;
                hold_at_beat = 0;
            end else if (hold_left > 0) begin
                hold_left--;
            end
            fifo_afull = (hold_left > 0) ? 1'b1 : (afull_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
            prev_cyc   = wb_cyc;
            prev_afull = fifo_afull;
            prev_we    = fifo_we;
        end
    end

    task automatic run_cmd(input logic [31:0] adr, input int len, input bit chk_lat);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", {63'd0, cmd_ready}, 64'd1);
        build_model(adr, len);
        done_cnt   = 0;
        beats_seen = 0;
        cur_len    = len;
        cmd_valid  = 1'b1;
        cmd_adr    = adr;
        cmd_len    = LEN_W'(len);
        @(negedge clk);
        cmd_valid  = 1'b0;
        if (len == 0) begin
            check("zero_done", {63'd0, done}, 64'd1);
            check("zero_ready", {63'd0, cmd_ready}, 64'd1);
        end else if (chk_lat) begin
            check("lat_wait", {63'd0, wb_cyc}, 64'd0);
            @(negedge clk);
            check("lat_burst", {63'd0, wb_cyc}, 64'd1);
        end
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        check("done_once", 64'(done_cnt), 64'd1);
        check("beats_left", 64'(exp_beats.size()), 64'd0);
        check("data_left", 64'(exp_data.size()), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_adr   = '0;
        cmd_len   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_cyc", {63'd0, wb_cyc}, 64'd0);
        check("rst_stb", {63'd0, wb_stb}, 64'd0);
        check("rst_we", {63'd0, fifo_we}, 64'd0);
        check("rst_adr", {32'd0, wb_adr}, 64'd0);
        check("rst_cti", {61'd0, wb_cti}, 64'd0);
        check("rst_wdata", {32'd0, fifo_wdata}, 64'd0);
        check("const_wbwe", {63'd0, wb_we}, 64'd0);
        check("const_sel", {60'd0, wb_sel}, 64'hF);
        check("const_bte", {62'd0, wb_bte}, 64'd0);
        check("const_dat", {32'd0, wb_dat_ms}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_cmd(32'h40, 5, 1);
        run_cmd(32'h100, 40, 1);
        run_cmd(32'h203, 1, 1);           // low address bits ignored
        run_cmd(32'h0, 0, 0);
        hold_at_beat = 16;                // afull high for 20 cycles after first burst
        run_cmd(32'h1000, 40, 0);
        wait_mode = 1;
        run_cmd(32'h2000, 35, 0);
        wait_mode = 0;
        run_cmd(32'hFFFF_FFF0, 10, 0);    // address wrap

        // randomized cases
        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255)) : $urandom;
            wait_mode  = ($urandom_range(0, 1) == 1);
            afull_rand = ($urandom_range(0, 1) == 1);
            run_cmd(a, $urandom_range(0, 40), 0);
        end
        wait_mode  = 0;
        afull_rand = 0;

        // reset during the third beat
        build_model(32'h800, 20);
        done_cnt   = 0;
        beats_seen = 0;
        cur_len    = 20;
        cmd_valid  = 1'b1;
        cmd_adr    = 32'h800;
        cmd_len    = LEN_W'(20);
        @(negedge clk);
        cmd_valid  = 1'b0;
        n = 0;
        while (beats_seen < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("rst_test_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #2;
        check("pre_rst_cyc", {63'd0, wb_cyc}, 64'd1);
        check("pre_rst_adr", {32'd0, wb_adr}, 64'h808);
        rst_n = 1'b0;
        #1;
        check("async_cyc", {63'd0, wb_cyc}, 64'd0);
        check("async_stb", {63'd0, wb_stb}, 64'd0);
        check("async_we", {63'd0, fifo_we}, 64'd0);
        exp_beats.delete();
        exp_data.delete();
        cur_len  = 0;
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("post_rst_done", {63'd0, done}, 64'd0);
        repeat (5) @(negedge clk);
        check("no_done_after_rst", 64'(done_cnt), 64'd0);
        run_cmd(32'h900, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
